mc_fsm_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle control decode with a Moore FSM that steps a shared ALU and a single shared instruction/data memory port through fetch, decode, execute, memory and writeback phases. It handles memory wait states with a ready handshake and a timeout trap. It sits between the IR fields and the datapath muxes, register file, PC and memory port.

---
 rtl/mc_fsm_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_mc_fsm_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mc_fsm_ctrl.sv
// Purpose : multi-cycle RV32I sequencer (Moore FSM) driving shared ALU, memory port, PC and regfile.
// Latency : zero-wait R/I 4, load 5, store 4, branch 3, jal/jalr 3 cycles per instruction.
// Backpr. : memory states hold until mem_ready; after WAIT_MAX stalled cycles the FSM traps (bus error).
//
// Ports: clk/rst_n (async active-low); opcode/funct3/funct7 from IR; mem_ready + ALU flags in;
//        memory port (mem_req, mem_we, mem_addr_sel), datapath mux/enable controls, sticky
//        trap/bus_err, instret counter and state_o debug out.
// Optional feature macro: MC_PERF_CNT_EN (instret retired-instruction counter; tied to 0 when undefined).
module mc_fsm_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             mem_ready,
  input  logic             flag_zero,
  input  logic             flag_lt,
  input  logic             flag_ltu,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  // Counter only needs to reach WAIT_MAX; with the timeout disabled it just wraps harmlessly.
  localparam int              WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [3:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              trap_q, bus_err_q;
  logic              timeout, br_take, br_illegal;

  function automatic logic [3:0] r_alu_op(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      10'b0000000_000: r_alu_op = ALU_ADD;
      10'b0100000_000: r_alu_op = ALU_SUB;
      10'b0000000_001: r_alu_op = ALU_SLL;
      10'b0000000_010: r_alu_op = ALU_SLT;
      10'b0000000_011: r_alu_op = ALU_SLTU;
      10'b0000000_100: r_alu_op = ALU_XOR;
      10'b0000000_101: r_alu_op = ALU_SRL;
      10'b0100000_101: r_alu_op = ALU_SRA;
      10'b0000000_110: r_alu_op = ALU_OR;
      10'b0000000_111: r_alu_op = ALU_AND;
      default:         r_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] i_alu_op(input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'b001:  i_alu_op = ALU_SLL;
      3'b010:  i_alu_op = ALU_SLT;
      3'b011:  i_alu_op = ALU_SLTU;
      3'b100:  i_alu_op = ALU_XOR;
      3'b101:  i_alu_op = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
      3'b110:  i_alu_op = ALU_OR;
      3'b111:  i_alu_op = ALU_AND;
      default: i_alu_op = ALU_ADD;
    endcase
  endfunction

  // funct3 010/011 are not branch encodings.
  assign br_illegal = (funct3[2:1] == 2'b01);

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = flag_zero;
      3'b001:  br_take = !flag_zero;
      3'b100:  br_take = flag_lt;
      3'b101:  br_take = !flag_lt;
      3'b110:  br_take = flag_ltu;
      3'b111:  br_take = !flag_ltu;
      default: br_take = 1'b0;
    endcase
  end

  // mem_ready at the limit cycle wins: timeout only fires while still stalled.
  assign timeout = (WAIT_MAX != 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LIM);

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE; else if (timeout) state_nxt = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL, OP_JALR:   state_nxt = S_JUMP;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM; else if (timeout) state_nxt = S_TRAP;
      S_MEM_WR: if (mem_ready) state_nxt = S_FETCH;  else if (timeout) state_nxt = S_TRAP;
      S_WB_ALU, S_WB_MEM, S_JUMP: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = br_illegal ? S_TRAP : S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  // Any state change clears the counter, which covers entry into every memory state.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state_nxt != state)        wait_cnt_nxt = '0;
    else if (mem_req && !mem_ready) wait_cnt_nxt = wait_cnt + 1'b1;
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_EXEC_R:   alu_op = r_alu_op(funct7, funct3);
      S_EXEC_I: begin
        alu_src_b = 2'd1;
        alu_op    = i_alu_op(funct7, funct3);
      end
      S_MEM_ADDR: alu_src_b = 2'd1;
      S_MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
      end
      S_WB_ALU:   reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        pc_src   = 1'b1;
        pc_write = br_take && !br_illegal;
      end
      S_JUMP: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        if (opcode == OP_JALR) alu_src_b = 2'd1;
        else                   pc_src    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == S_TRAP) trap_q    <= 1'b1;
      if (timeout)             bus_err_q <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_JUMP) ||
                  (state == S_MEM_WR && mem_ready) || (state == S_BRANCH && !br_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 1'b1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

  assign trap    = trap_q;
  assign bus_err = bus_err_q;
  assign state_o = state;

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
module tb_mc_fsm_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        mem_ready, flag_zero, flag_lt, flag_ltu;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alu_op, state_o;
  logic        reg_write, trap, bus_err;
  logic [31:0] instret;

  int errs   = 0;
  int checks = 0;

  mc_fsm_ctrl #(.WAIT_MAX(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .flag_zero(flag_zero), .flag_lt(flag_lt), .flag_ltu(flag_ltu),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap), .bus_err(bus_err),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and land 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  function automatic logic [31:0] perf(input int n);
`ifdef MC_PERF_CNT_EN
    perf = n;
`else
    perf = 0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0;
    flag_zero = 1'b0; flag_lt = 1'b0; flag_ltu = 1'b0;
    set_ir(7'd0, 3'd0, 7'd0);
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_trap", {trap, bus_err}, 0);
    chk("rst_instret", instret, 0);

    // add: 0,1,2,3,8,1
    rst_n = 1'b1; mem_ready = 1'b1; set_ir(OP_R, 3'd0, 7'd0); #1;
    chk("rel_state", state_o, 0);
    chk("rel_outs", {mem_req, ir_write, pc_write, reg_write, alu_src_a, alu_src_b}, 0);
    step(); chk("add_fetch", state_o, 1);
    chk("fetch_ctl", {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                      alu_src_a, alu_src_b, alu_op}, 32'h2660);
    step(); chk("add_decode", state_o, 2);
    chk("decode_ctl", {alu_src_a, alu_src_b, alu_op}, 32'h90);
    step(); chk("add_exec", state_o, 3);
    chk("add_aluop", {alu_src_a, alu_src_b, alu_op}, 0);
    step(); chk("add_wb", state_o, 8);
    chk("add_wb_ctl", {reg_write, wb_sel}, 3'b100);
    step(); chk("add_back", state_o, 1);
    chk("add_rw_off", reg_write, 0);

    // lw with 3 stalled MEM_RD cycles; the 4th arrives exactly at WAIT_MAX and completes
    set_ir(OP_LOAD, 3'b010, 7'd0);
    step(); chk("lw_dec", state_o, 2);
    step(); chk("lw_addr", state_o, 5);
    step(); chk("lw_rd1", state_o, 6);
    mem_ready = 1'b0; #1;
    chk("lw_rd_ctl", {mem_req, mem_we, mem_addr_sel}, 3'b101);
    step(); chk("lw_rd2", state_o, 6);
    step(); chk("lw_rd3", state_o, 6);
    step(); chk("lw_rd4", state_o, 6);
    mem_ready = 1'b1;
    step(); chk("lw_wbmem", state_o, 9);
    chk("lw_wb_ctl", {reg_write, wb_sel}, 3'b101);
    step(); chk("lw_back", state_o, 1);

    // sw
    set_ir(OP_STORE, 3'b010, 7'd0);
    step(); step(); step(); chk("sw_wr", state_o, 7);
    chk("sw_ctl", {mem_req, mem_we, mem_addr_sel}, 3'b111);
    step(); chk("sw_back", state_o, 1);

    // beq taken
    set_ir(OP_BR, 3'b000, 7'd0); flag_zero = 1'b1;
    step(); step(); chk("beq_st", state_o, 10);
    chk("beq_ctl", {pc_write, pc_src, alu_op}, 6'b110001);
    step(); chk("beq_back", state_o, 1);

    // jal
    set_ir(OP_JAL, 3'b000, 7'd0);
    step(); step(); chk("jal_st", state_o, 11);
    chk("jal_ctl", {reg_write, wb_sel, pc_write, pc_src}, 5'b11011);
    step(); chk("jal_back", state_o, 1);
    chk("instret5", instret, perf(5));

    // bne not taken
    set_ir(OP_BR, 3'b001, 7'd0);
    step(); step(); chk("bne_st", state_o, 10);
    chk("bne_pcw", pc_write, 0);
    step();

    // jalr
    set_ir(OP_JALR, 3'b000, 7'd0);
    step(); step(); chk("jalr_st", state_o, 11);
    chk("jalr_ctl", {pc_src, alu_src_a, alu_src_b, alu_op}, 32'h10);
    step();

    // sub
    set_ir(OP_R, 3'b000, 7'b0100000);
    step(); step(); chk("sub_st", state_o, 3);
    chk("sub_op", alu_op, 1);
    step(); step();

    // srai
    set_ir(OP_I, 3'b101, 7'b0100000);
    step(); step(); chk("srai_st", state_o, 4);
    chk("srai_ctl", {alu_src_b, alu_op}, 6'b010111);
    step(); step(); chk("srai_back", state_o, 1);
    chk("instret9", instret, perf(9));

    // illegal branch funct3
    set_ir(OP_BR, 3'b010, 7'd0);
    step(); step(); chk("bad_br_st", state_o, 10);
    chk("bad_br_pcw", pc_write, 0);
    step(); chk("bad_br_trap", state_o, 12);
    chk("bad_br_flags", {trap, bus_err}, 2'b10);
    step(); chk("trap_sticky", state_o, 12);
    rst_n = 1'b0; #1;
    chk("rst2_state", state_o, 0);
    chk("rst2_flags", {trap, bus_err, instret}, 0);
    step(); rst_n = 1'b1;

    // illegal opcode
    set_ir(7'b0000000, 3'd0, 7'd0);
    step(); step(); chk("ill_dec", state_o, 2);
    step(); chk("ill_trap", state_o, 12);
    chk("ill_trapflag", trap, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // reset in the middle of a stalled store
    set_ir(OP_STORE, 3'b010, 7'd0);
    step(); step(); step(); step(); chk("mid_wr", state_o, 7);
    mem_ready = 1'b0;
    step(); chk("mid_wr_hold", {state_o, mem_req}, {4'd7, 1'b1});
    rst_n = 1'b0; #1;
    chk("mid_rst", {state_o, mem_req, mem_we}, 0);

    // fetch timeout with WAIT_MAX=3
    step(); rst_n = 1'b1;
    step(); chk("to_f1", state_o, 1);
    step(); step(); step(); chk("to_f4", state_o, 1);
    step(); chk("to_trap", state_o, 12);
    chk("to_flags", {trap, bus_err, mem_req}, 3'b110);
    mem_ready = 1'b1;
    step(); chk("to_stay", {state_o, mem_req}, {4'd12, 1'b0});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
